// File: rtl/bp_update_ctrl_pkg.sv
// Shared types for the branch-predictor update sequencer.
//   bp_upd_t    : one resolved-branch update as queued in the update FIFO
//   bpc_state_t : sequencer state (clear cycle / running)
package bp_update_ctrl_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic        taken;
    logic        ualigc;
    logic        btb;
    logic [11:0] offset;
    logic [31:0] add;
  } bp_upd_t;

  typedef enum logic {
    BPC_CLR = 1'b0,
    BPC_RUN = 1'b1
  } bpc_state_t;

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// bp_upd_fifo: small FIFO of bp_upd_t entries.
//   clk, reset : clock, synchronous active-high reset
//   clear      : empties the FIFO, overrides push/pop
//   push, din  : write an entry (ignored when full unless popping)
//   pop        : drop the head entry (caller only pops when non-empty)
//   head       : current head entry
//   full/empty : occupancy flags
module bp_upd_fifo
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    clear,
  input  logic    push,
  input  logic    pop,
  input  bp_upd_t din,
  output bp_upd_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  bp_upd_t       mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Pointers are log2(DEPTH) wide, so they wrap mod DEPTH for free.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: sequences resolved-branch updates, single-entry BTB
// invalidations and whole-predictor flushes onto the branch predictor ports.
//   s_clk_i, s_reset_i           : clock, synchronous active-high reset
//   s_upd_*                      : update request channel (valid/ready + fields)
//   s_inv_req_i, s_inv_add_i     : invalidate-one-entry pulse and address
//   s_flush_i                    : clear-whole-predictor pulse
//   s_enable_i                   : 0 discards queued updates instead of issuing
//   s_bp_*                       : predictor update/invalidate/clear outputs
//   s_busy_o                     : work outstanding or clear in progress
//   s_upd_cnt_o                  : saturating count of issued updates
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             s_clk_i,
  input  logic             s_reset_i,
  input  logic             s_upd_valid_i,
  output logic             s_upd_ready_o,
  input  logic             s_upd_taken_i,
  input  logic             s_upd_ualigc_i,
  input  logic             s_upd_btb_i,
  input  logic [11:0]      s_upd_offset_i,
  input  logic [31:0]      s_upd_add_i,
  input  logic             s_inv_req_i,
  input  logic [31:0]      s_inv_add_i,
  input  logic             s_flush_i,
  input  logic             s_enable_i,
  output logic             s_bp_update_o,
  output logic             s_bp_taken_o,
  output logic             s_bp_ualigc_o,
  output logic             s_bp_btb_o,
  output logic [11:0]      s_bp_offset_o,
  output logic [31:0]      s_bp_add_o,
  output logic             s_bp_invalidate_o,
  output logic             s_bp_resetn_o,
  output logic             s_busy_o,
  output logic [CNT_W-1:0] s_upd_cnt_o
);

  bpc_state_t state, state_nxt;
  logic       run, act, do_inv, pop, do_upd, push, clear;
  logic       full, empty;
  logic       inv_pend;
  logic [31:0] inv_add;
  bp_upd_t    head, din;

  assign din = '{taken: s_upd_taken_i, ualigc: s_upd_ualigc_i, btb: s_upd_btb_i,
                 offset: s_upd_offset_i, add: s_upd_add_i};

  // A flush in RUN suppresses every issue that cycle.
  assign run    = (state == BPC_RUN);
  assign act    = run & ~s_flush_i;
  assign do_inv = act & inv_pend;
  assign pop    = act & ~inv_pend & ~empty;
  assign do_upd = pop & s_enable_i;
  assign clear  = ~run | s_flush_i;

  assign s_upd_ready_o = run & (~full | pop);
  assign push          = s_upd_valid_i & s_upd_ready_o;

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (s_clk_i),
    .reset (s_reset_i),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) state <= BPC_CLR;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BPC_CLR: state_nxt = BPC_RUN;
      BPC_RUN: if (s_flush_i) state_nxt = BPC_CLR;
      default: state_nxt = BPC_CLR;
    endcase
  end

  // A new request overrides an issue in the same cycle (last one wins).
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i || clear) begin
      inv_pend <= 1'b0;
      inv_add  <= '0;
    end else if (s_inv_req_i) begin
      inv_pend <= 1'b1;
      inv_add  <= s_inv_add_i;
    end else if (do_inv) begin
      inv_pend <= 1'b0;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i)                         s_upd_cnt_o <= '0;
    else if (do_upd && s_upd_cnt_o != CNT_MAX) s_upd_cnt_o <= s_upd_cnt_o + 1'b1;
  end

  always_comb begin
    s_bp_update_o     = do_upd;
    s_bp_invalidate_o = do_inv;
    s_bp_taken_o      = 1'b0;
    s_bp_ualigc_o     = 1'b0;
    s_bp_btb_o        = 1'b0;
    s_bp_offset_o     = '0;
    s_bp_add_o        = '0;
    if (do_inv) begin
      s_bp_add_o = inv_add;
    end else if (do_upd) begin
      s_bp_taken_o  = head.taken;
      s_bp_ualigc_o = head.ualigc;
      s_bp_btb_o    = head.btb;
      s_bp_offset_o = head.offset;
      s_bp_add_o    = head.add;
    end
  end

  assign s_bp_resetn_o = run;
  assign s_busy_o      = ~empty | inv_pend | ~run;

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0, upd_ready;
  logic        upd_taken = 1'b0, upd_ualigc = 1'b0, upd_btb = 1'b0;
  logic [11:0] upd_offset = '0;
  logic [31:0] upd_add = '0;
  logic        inv_req = 1'b0;
  logic [31:0] inv_add = '0;
  logic        flush = 1'b0, enable = 1'b1;
  logic        bp_update, bp_taken, bp_ualigc, bp_btb, bp_invalidate, bp_resetn, busy;
  logic [11:0] bp_offset;
  logic [31:0] bp_add;
  logic [15:0] upd_cnt;

  bp_update_ctrl #(.DEPTH(DEPTH)) dut (
    .s_clk_i(clk), .s_reset_i(rst),
    .s_upd_valid_i(upd_valid), .s_upd_ready_o(upd_ready),
    .s_upd_taken_i(upd_taken), .s_upd_ualigc_i(upd_ualigc), .s_upd_btb_i(upd_btb),
    .s_upd_offset_i(upd_offset), .s_upd_add_i(upd_add),
    .s_inv_req_i(inv_req), .s_inv_add_i(inv_add),
    .s_flush_i(flush), .s_enable_i(enable),
    .s_bp_update_o(bp_update), .s_bp_taken_o(bp_taken), .s_bp_ualigc_o(bp_ualigc),
    .s_bp_btb_o(bp_btb), .s_bp_offset_o(bp_offset), .s_bp_add_o(bp_add),
    .s_bp_invalidate_o(bp_invalidate), .s_bp_resetn_o(bp_resetn),
    .s_busy_o(busy), .s_upd_cnt_o(upd_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One expected predictor operation: kind, packed {taken,ualigc,btb,offset,add}, cycle.
  typedef struct {
    bit        inv;
    bit [46:0] data;
    int        cyc;
  } exp_t;

  exp_t      q[$];
  bit [46:0] mq[$];          // reference FIFO contents
  bit        m_run  = 0;     // DUT is in RUN this cycle
  bit        m_pend = 0;
  bit [31:0] m_padd = '0;
  int        m_cnt  = 0;
  bit        e_ready, e_resetn, e_busy;
  int        e_cnt;
  bit        started = 0;
  int        tests = 0, fails = 0;

  function automatic bit [46:0] mk(bit [31:0] a);
    return {3'($urandom), 12'($urandom), a};
  endfunction

  // Drive one cycle of inputs and advance the reference model by one cycle.
  task automatic step(bit r, bit v, bit [46:0] d, bit inv, bit [31:0] ia, bit fl, bit en);
    @(posedge clk); #1;
    rst = r; upd_valid = v; {upd_taken, upd_ualigc, upd_btb, upd_offset, upd_add} = d;
    inv_req = inv; inv_add = ia; flush = fl; enable = en;
    e_cnt  = m_cnt;
    e_busy = !m_run || mq.size() > 0 || m_pend;
    if (r) begin
      e_ready = 0; e_resetn = 0; e_busy = 1;
      m_run = 0; mq.delete(); m_pend = 0; m_cnt = 0; e_cnt = 0;
    end else if (!m_run) begin
      e_ready = 0; e_resetn = 0;
      m_run = 1; mq.delete(); m_pend = 0;
    end else if (fl) begin
      e_resetn = 1; e_ready = mq.size() < DEPTH;
      m_run = 0; mq.delete(); m_pend = 0;
    end else begin
      e_resetn = 1;
      if (m_pend) begin
        q.push_back('{1'b1, {15'b0, m_padd}, cyc});
        m_pend = 0;
      end else if (mq.size() > 0) begin
        bit [46:0] h;
        h = mq.pop_front();
        if (en) begin
          q.push_back('{1'b0, h, cyc});
          if (m_cnt < 65535) m_cnt++;
        end
      end
      e_ready = mq.size() < DEPTH;
      if (v && e_ready) mq.push_back(d);
      if (inv) begin m_pend = 1; m_padd = ia; end
    end
    started = 1;
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on each issue.
  always @(negedge clk) begin
    if (started) begin
      logic [46:0] got;
      exp_t        e;
      got = {bp_taken, bp_ualigc, bp_btb, bp_offset, bp_add};
      tests++;
      if ({upd_ready, bp_resetn, busy} !== {e_ready, e_resetn, e_busy} || upd_cnt !== e_cnt[15:0]) begin
        fails++;
        $display("FAIL status cyc=%0d: ready/resetn/busy=%b%b%b cnt=%h, want %b%b%b cnt=%h",
                 cyc, upd_ready, bp_resetn, busy, upd_cnt, e_ready, e_resetn, e_busy, e_cnt[15:0]);
      end
      if (bp_update === 1'b1 || bp_invalidate === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_op cyc=%0d: upd=%b inv=%b data=%h, want none", cyc, bp_update, bp_invalidate, got);
        end else begin
          e = q.pop_front();
          if (bp_invalidate !== e.inv || bp_update !== !e.inv || got !== e.data || e.cyc != cyc) begin
            fails++;
            $display("FAIL op cyc=%0d: upd=%b inv=%b data=%h, want inv=%b data=%h at cyc=%0d",
                     cyc, bp_update, bp_invalidate, got, e.inv, e.data, e.cyc);
          end
        end
      end else begin
        tests++;
        if (got !== '0 || bp_update !== 1'b0 || bp_invalidate !== 1'b0) begin
          fails++;
          $display("FAIL idle_outputs cyc=%0d: data=%h upd=%b inv=%b, want 0", cyc, got, bp_update, bp_invalidate);
        end
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          tests++; fails++;
          $display("FAIL missing_op cyc=%0d: nothing issued, want inv=%b data=%h", cyc, q[0].inv, q[0].data);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) step(1, 0, '0, 0, 0, 0, 1);
    repeat (3) step(0, 0, '0, 0, 0, 0, 1);
    // back-to-back updates 0x100..0x10C
    for (int i = 0; i < 4; i++) step(0, 1, mk(32'h100 + 32'(4*i)), 0, 0, 0, 1);
    repeat (3) step(0, 0, '0, 0, 0, 0, 1);
    // invalidations every cycle stall the FIFO until it fills, then drain while pushing
    for (int i = 0; i < 7; i++) step(0, 1, mk(32'h400 + 32'(4*i)), 1, 32'h500 + 32'(i), 0, 1);
    for (int i = 0; i < 5; i++) step(0, 1, mk(32'h480 + 32'(4*i)), 0, 0, 0, 1);
    repeat (6) step(0, 0, '0, 0, 0, 0, 1);
    // invalidation and push in the same cycle
    step(0, 1, mk(32'h300), 1, 32'h200, 0, 1);
    repeat (3) step(0, 0, '0, 0, 0, 0, 1);
    // flush with queued updates and a pending invalidation
    for (int i = 0; i < 3; i++) step(0, 1, mk(32'h600 + 32'(4*i)), 1, 32'h700 + 32'(i), 0, 1);
    step(0, 1, mk(32'h6F0), 1, 32'h7F0, 1, 1);
    repeat (3) step(0, 0, '0, 0, 0, 0, 1);
    // disabled: updates are popped but never issued
    step(0, 1, mk(32'h800), 0, 0, 0, 0);
    step(0, 1, mk(32'h804), 0, 0, 0, 0);
    repeat (3) step(0, 0, '0, 0, 0, 0, 0);
    // random mix
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 9) < 6, mk($urandom), $urandom_range(0, 9) < 2, $urandom,
           $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 8);
    // drive the counter into saturation
    for (int i = 0; i < 65600; i++) step(0, 1, mk($urandom), 0, 0, 0, 1);
    repeat (4) step(0, 0, '0, 0, 0, 0, 1);
    @(negedge clk); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected ops never issued, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
